// File: rtl/microsequencer_if.sv
// microsequencer_if: pipeline-register fields into the sequencer, next address and stack status out
interface microsequencer_if #(
  parameter int ADDR_W = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
);
  logic [2:0] op;
  logic [ADDR_W-1:0] d, r_in, or_mask, uaddr;
  logic r_load, cond, cond_pol, hold;
  logic [SP_W-1:0] sp;
  logic stack_empty, stack_full, stack_err;
  modport master (
    output op, d, r_in, r_load, or_mask, cond, cond_pol, hold,
    input uaddr, sp, stack_empty, stack_full, stack_err
  );
  modport slave (
    input op, d, r_in, r_load, or_mask, cond, cond_pol, hold,
    output uaddr, sp, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/microsequencer.sv
// microsequencer: next-microaddress generator with upc, address register and return stack
module microsequencer #(
  parameter int ADDR_W = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input logic clock,
  input logic reset,
  microsequencer_if.slave bus
);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [2:0] {CONT, JMP, JMPR, CJMP, CALL, RET, CASE, LOOP} op_e;
  op_e op;
  logic ct, has, full, push, pop, err, err_q;
  logic [ADDR_W-1:0] upc_q, upc_d, areg_q, top, nxt;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  assign op = op_e'(bus.op);
  assign ct = bus.cond ^ bus.cond_pol;
  assign has = sp_q != '0;
  assign full = sp_q == SP_W'(STACK_DEPTH);
  // top is only consumed when has=1, so the wrapped index at sp=0 is never used
  assign top = stack_q[IW'(sp_q - 1'b1)];
  always_comb begin
    nxt = op == CONT ? upc_q : op == JMP ? bus.d : op == JMPR ? areg_q :
          (op == CJMP || op == CALL) ? (ct ? bus.d : upc_q) :
          op == RET ? (has ? top : upc_q) : op == CASE ? (bus.d | bus.or_mask) :
          ((ct || !has) ? upc_q : top);
    push = op == CALL && ct;
    pop = has && (op == RET || (op == LOOP && ct));
    err = (push && full) || (!has && (op == RET || (op == LOOP && ct)));
    sp_d = (push && !full) ? sp_q + 1'b1 : pop ? sp_q - 1'b1 : sp_q;
    upc_d = nxt + 1'b1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      upc_q <= '0;
      areg_q <= '0;
      sp_q <= '0;
      err_q <= 1'b0;
      stack_q <= '{default: '0};
    end else if (!bus.hold) begin
      upc_q <= upc_d;
      sp_q <= sp_d;
      err_q <= err_q | err;
      if (bus.r_load) areg_q <= bus.r_in;
      if (push && !full) stack_q[IW'(sp_q)] <= upc_q;
    end
  assign bus.uaddr = reset ? '0 : nxt;
  assign bus.sp = sp_q;
  assign bus.stack_empty = !has;
  assign bus.stack_full = full;
  assign bus.stack_err = err_q;
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed and random checks against a queue-based sequencer model
module tb_microsequencer;
  localparam int AW = 11;
  localparam int SD = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  microsequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();
  microsequencer #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] m_upc, m_areg;
  logic [AW-1:0] m_stk[$];
  logic m_err;
  function automatic logic [AW-1:0] m_next();
    logic c = bus.cond ^ bus.cond_pol;
    int n = m_stk.size();
    case (bus.op)
      3'd0: return m_upc;
      3'd1: return bus.d;
      3'd2: return m_areg;
      3'd3, 3'd4: return c ? bus.d : m_upc;
      3'd5: return n > 0 ? m_stk[n-1] : m_upc;
      3'd6: return bus.d | bus.or_mask;
      default: return (c || n == 0) ? m_upc : m_stk[n-1];
    endcase
  endfunction
  task automatic tick();
    logic [AW-1:0] u = m_next();
    logic c = bus.cond ^ bus.cond_pol;
    @(posedge clock);
    #1;
    if (!bus.hold) begin
      if (bus.op == 3'd4 && c) begin
        if (m_stk.size() < SD) m_stk.push_back(m_upc);
        else m_err = 1'b1;
      end
      if (bus.op == 3'd5 || (bus.op == 3'd7 && c)) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1'b1;
      end
      if (bus.r_load) m_areg = bus.r_in;
      m_upc = u + 1'b1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_upc = '0;
    m_areg = '0;
    m_stk.delete();
    m_err = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  task automatic drv(input int o, input int dd, input bit c = 1'b0);
    bus.op = 3'(o);
    bus.d = AW'(dd);
    bus.cond = c;
    bus.cond_pol = 1'b0;
    bus.r_load = 1'b0;
    bus.r_in = '0;
    bus.or_mask = '0;
    bus.hold = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    drv(1, 'h555);
    n_vec++; if (bus.uaddr !== 11'h000) begin n_err++; $display("FAIL reset_uaddr got=%h exp=000", bus.uaddr); end
    n_vec++; if ({bus.sp, bus.stack_empty, bus.stack_full, bus.stack_err} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_flags got sp=%0d e=%b f=%b err=%b", bus.sp, bus.stack_empty, bus.stack_full, bus.stack_err);
    end
  endtask
  task automatic test_increment();
    do_reset();
    drv(0, 0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.uaddr !== AW'(i)) begin n_err++; $display("FAIL incr%0d got=%h exp=%h", i, bus.uaddr, AW'(i)); end
      tick();
    end
    drv(1, 'h7FF);
    tick();
    drv(0, 0);
    n_vec++; if (bus.uaddr !== 11'h000) begin n_err++; $display("FAIL wrap got=%h exp=000", bus.uaddr); end
    tick();
  endtask
  task automatic test_cond_branch();
    do_reset();
    drv(1, 'h00F);
    tick();
    drv(3, 'h123, 1'b1);
    n_vec++; if (bus.uaddr !== 11'h123) begin n_err++; $display("FAIL cjmp_taken got=%h exp=123", bus.uaddr); end
    bus.cond_pol = 1'b1;
    #1;
    n_vec++; if (bus.uaddr !== 11'h010) begin n_err++; $display("FAIL cjmp_inv got=%h exp=010", bus.uaddr); end
  endtask
  task automatic test_call_ret();
    do_reset();
    drv(1, 'h020);
    tick();
    drv(4, 'h100, 1'b1);
    tick();
    drv(4, 'h200, 1'b1);
    tick();
    n_vec++; if (bus.sp !== 3'd2) begin n_err++; $display("FAIL call_sp got=%0d exp=2", bus.sp); end
    drv(5, 0);
    n_vec++; if (bus.uaddr !== 11'h101) begin n_err++; $display("FAIL ret1 got=%h exp=101", bus.uaddr); end
    tick();
    n_vec++; if (bus.uaddr !== 11'h021) begin n_err++; $display("FAIL ret2 got=%h exp=021", bus.uaddr); end
    tick();
    n_vec++; if ({bus.sp, bus.stack_empty, bus.stack_err} !== {3'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL ret_flags got sp=%0d e=%b err=%b exp sp=0 e=1 err=0", bus.sp, bus.stack_empty, bus.stack_err);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(4, 'h100 + i * 'h10, 1'b1);
      n_vec++; if (bus.uaddr !== AW'('h100 + i * 'h10)) begin n_err++; $display("FAIL ovf_jump%0d got=%h exp=%h", i, bus.uaddr, AW'('h100 + i * 'h10)); end
      if (i == 4) begin
        n_vec++; if (bus.stack_err !== 1'b0) begin n_err++; $display("FAIL ovf_early_err got=%b exp=0", bus.stack_err); end
      end
      tick();
    end
    n_vec++; if ({bus.sp, bus.stack_full, bus.stack_err} !== {3'd4, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL ovf_flags got sp=%0d f=%b err=%b exp sp=4 f=1 err=1", bus.sp, bus.stack_full, bus.stack_err);
    end
    do_reset();
    n_vec++; if ({bus.sp, bus.stack_err} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL reset_clears got sp=%0d err=%b", bus.sp, bus.stack_err); end
    drv(0, 0);
    tick();
    drv(5, 'h3AA);
    n_vec++; if (bus.uaddr !== 11'h001) begin n_err++; $display("FAIL unf_uaddr got=%h exp=001", bus.uaddr); end
    tick();
    n_vec++; if ({bus.sp, bus.stack_err} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL unf_flags got sp=%0d err=%b exp sp=0 err=1", bus.sp, bus.stack_err); end
  endtask
  task automatic test_case_reg();
    do_reset();
    drv(6, 'h300);
    bus.or_mask = 11'h00B;
    #1;
    n_vec++; if (bus.uaddr !== 11'h30B) begin n_err++; $display("FAIL case got=%h exp=30B", bus.uaddr); end
    tick();
    drv(0, 0);
    bus.r_load = 1'b1;
    bus.r_in = 11'h2AA;
    tick();
    drv(2, 0);
    bus.r_load = 1'b1;
    bus.r_in = 11'h456;
    #1;
    n_vec++; if (bus.uaddr !== 11'h2AA) begin n_err++; $display("FAIL jmpr_old got=%h exp=2AA", bus.uaddr); end
    tick();
    drv(2, 0);
    n_vec++; if (bus.uaddr !== 11'h456) begin n_err++; $display("FAIL jmpr_new got=%h exp=456", bus.uaddr); end
    tick();
  endtask
  task automatic test_hold_loop();
    do_reset();
    drv(1, 'h050);
    tick();
    drv(4, 'h100, 1'b1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (bus.sp !== 3'd0) begin n_err++; $display("FAIL hold_sp got=%0d exp=0", bus.sp); end
    bus.op = 3'd0;
    #1;
    n_vec++; if (bus.uaddr !== 11'h051) begin n_err++; $display("FAIL hold_upc got=%h exp=051", bus.uaddr); end
    drv(1, 'h03F);
    tick();
    drv(4, 'h060, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(7, 0, 1'b0);
      n_vec++; if (bus.uaddr !== 11'h040) begin n_err++; $display("FAIL loop%0d got=%h exp=040", i, bus.uaddr); end
      tick();
    end
    drv(7, 0, 1'b1);
    n_vec++; if (bus.uaddr !== 11'h041) begin n_err++; $display("FAIL loop_exit got=%h exp=041", bus.uaddr); end
    tick();
    n_vec++; if ({bus.sp, bus.stack_err} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL loop_flags got sp=%0d err=%b exp sp=0 err=0", bus.sp, bus.stack_err); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] e;
      if (i % 100 == 0) do_reset();
      bus.op = 3'($urandom_range(0, 7));
      bus.d = AW'($urandom);
      bus.r_in = AW'($urandom);
      bus.r_load = 1'($urandom);
      bus.or_mask = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : '0;
      bus.cond = 1'($urandom);
      bus.cond_pol = 1'($urandom);
      bus.hold = $urandom_range(0, 7) == 0;
      #1;
      e = m_next();
      n_vec++; if (bus.uaddr !== e) begin n_err++; $display("FAIL rnd_uaddr%0d op=%0d got=%h exp=%h", i, bus.op, bus.uaddr, e); end
      tick();
      n_vec++;
      if ({bus.sp, bus.stack_empty, bus.stack_full, bus.stack_err} !==
          {3'(m_stk.size()), m_stk.size() == 0, m_stk.size() == SD, m_err}) begin
        n_err++;
        $display("FAIL rnd_flags%0d got sp=%0d e=%b f=%b err=%b exp sp=%0d err=%b",
                 i, bus.sp, bus.stack_empty, bus.stack_full, bus.stack_err, m_stk.size(), m_err);
      end
    end
  endtask
  initial begin
    drv(0, 0);
    test_reset();
    test_increment();
    test_cond_branch();
    test_call_ret();
    test_overflow();
    test_case_reg();
    test_hold_loop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogram sequencer that replaces the cascaded 4-bit Am2909/Am2911 slices with a single block of configurable address width and subroutine-stack depth. It computes the next microcode ROM address combinationally from the pipeline register fields, condition input, register input and case OR-mask. It holds the microprogram counter, address register and return stack. It sits between the pipeline register and the microcode ROM address port. Over the slice cascade it adds conditional call, a loop primitive, a wide case OR-mask, and stack full/empty/error status.

## Interface
Parameters:
- ADDR_W, 11, microcode address width (≥4)
- STACK_DEPTH, 4, return-stack entries (≥2)
- SP_W, $clog2(STACK_DEPTH+1), stack-pointer width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  3  next-address operation (see Operation)
- d  in  ADDR_W  direct/branch address from pipeline
- r_in  in  ADDR_W  address-register load value (F bus)
- r_load  in  1  load address register from r_in
- or_mask  in  ADDR_W  case OR inputs
- cond  in  1  raw condition
- cond_pol  in  1  1 = invert cond
- hold  in  1  freeze all sequential state
- uaddr  out  ADDR_W  next microaddress to ROM (combinational)
- sp  out  SP_W  stack occupancy, 0..STACK_DEPTH
- stack_empty  out  1  sp == 0
- stack_full  out  1  sp == STACK_DEPTH
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- Internal state: upc (ADDR_W), areg (ADDR_W), stack[STACK_DEPTH] (ADDR_W each), sp, stack_err.
- ct = cond ^ cond_pol.
- op decode (uaddr / stack action):
  - 0 CONT: upc / none
  - 1 JMP: d / none
  - 2 JMPR: areg / none
  - 3 CJMP: ct ? d : upc / none
  - 4 CALL: ct ? d : upc / push upc if ct
  - 5 RET: sp>0 ? stack[sp-1] : upc / pop if sp>0
  - 6 CASE: d | or_mask / none
  - 7 LOOP: ct ? upc : stack[sp-1] / pop if ct. If sp==0: uaddr=upc, no pop.
- Push onto a full stack: the entry is discarded, sp is unchanged, stack_err is set, and the jump to d is still taken.
- Pop from an empty stack (RET or LOOP with sp==0): stack_err is set. LOOP sets it only when ct=1.
- stack_err is cleared only by reset.
- Each clock with hold=0:
  - upc ← uaddr + 1, modulo 2^ADDR_W (wraps at all-ones to 0)
  - stack/sp update per op
  - areg ← r_in if r_load
- JMPR in the same cycle as r_load uses the old areg.
- hold=1: no state changes. uaddr is still computed from current state; repeated evaluation is harmless.
- While reset is asserted, uaddr is forced to 0, overriding op.

## Timing
- uaddr is purely combinational from op/d/or_mask/cond/cond_pol/areg/upc/stack: zero-cycle latency. The external ROM/pipeline register adds the one-cycle pipeline.
- Sequential state changes only on the rising edge of clock, or asynchronously on reset.
- Reset values:
  - upc=0, areg=0, sp=0, all stack entries=0, stack_err=0
  - outputs: uaddr=0, stack_empty=1, stack_full=0
- First edge after reset deasserts with op=CONT: uaddr=0 during that cycle, upc becomes 1.
- Reset mid-call discards all stack contents.
- sp, stack_empty, stack_full and stack_err are registered-state derived and valid in the cycle after the causing edge.
- Push and pop never occur in the same cycle; op is a single encoding.

## Test plan
- Reset and increment: assert reset, release, then op=CONT for 3 clocks -> uaddr sequence 0,1,2. Set upc to 0x7FF via JMP d=0x7FF, then CONT -> uaddr 0x000 (wrap).
- Conditional branch: upc=0x010, op=CJMP d=0x123. With cond=1, cond_pol=0 -> uaddr 0x123. With cond=1, cond_pol=1 -> uaddr 0x010.
- Call/return nesting: CALL d=0x100 at uaddr 0x020, then CALL d=0x200 at 0x100 -> sp=2. RET -> uaddr 0x101. RET -> uaddr 0x021, sp=0, stack_err=0.
- Overflow/underflow: five taken CALLs with STACK_DEPTH=4 -> sp=4, stack_full=1, stack_err=1, fifth jump still taken. After reset, RET with sp=0 -> uaddr=upc, stack_err=1.
- Case and register: d=0x300, or_mask=0x00B, op=CASE -> uaddr 0x30B. r_load with r_in=0x456 plus JMPR in the same cycle -> uaddr=old areg. JMPR next cycle -> uaddr 0x456.
- Hold and loop: hold=1 during CALL -> sp unchanged, upc unchanged over 3 clocks. Push 0x040, then LOOP with cond=0 twice -> uaddr 0x040 both times. LOOP with cond=1 -> uaddr=upc, sp=0.
